// File: rtl/dmx_frac_brg_if.sv
// Control and tick bundle for the DMX-512 fractional baud-rate generator.
// The master side drives run/sync/divisor loads; the slave side returns the enables.
interface dmx_frac_brg_if #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
);
    logic              run;
    logic              sync;
    logic [INT_W-1:0]  divInt;
    logic [FRAC_W-1:0] divFrac;
    logic              divLoad;
    logic              divBusy;
    logic              osEn;
    logic              midEn;
    logic              bitEn;

    modport master (
        output run, sync, divInt, divFrac, divLoad,
        input  divBusy, osEn, midEn, bitEn
    );

    modport slave (
        input  run, sync, divInt, divFrac, divLoad,
        output divBusy, osEn, midEn, bitEn
    );
endinterface

// File: rtl/dmx_frac_brg.sv
// Fractional-N baud-rate generator: oversample, bit-centre and bit-end enables
// with a shadowed divisor that switches only on bit boundaries or while idle.
module dmx_frac_brg #(
    parameter int INT_W      = 16,
    parameter int FRAC_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int RESET_INT  = 12,
    parameter int RESET_FRAC = 128
) (
    input logic           clk,
    input logic           rst,
    dmx_frac_brg_if.slave bus
);
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [INT_W-1:0]  RST_INT  = (RESET_INT < 2) ? INT_W'(2) : INT_W'(RESET_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_FRAC);
    localparam logic [IDX_W-1:0]  IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(OVERSAMPLE - 1);

    function automatic logic [INT_W-1:0] clamp_int(input logic [INT_W-1:0] v);
        return (v < INT_W'(2)) ? INT_W'(2) : v;
    endfunction

    logic [INT_W-1:0]  int_act, int_shd, cnt;
    logic [FRAC_W-1:0] frac_act, frac_shd, facc;
    logic [IDX_W-1:0]  os_idx;
    logic              div_busy, os_en, mid_en, bit_en;

    logic              restart, terminal, bit_end, apply;
    logic [INT_W-1:0]  int_eff;
    logic [FRAC_W:0]   fsum;

    assign restart  = !bus.run || bus.sync;
    assign terminal = (cnt == '0);
    assign bit_end  = !restart && terminal && (os_idx == IDX_LAST);
    // A pending divisor lands on a bit boundary, an idle cycle or a resync.
    assign apply    = div_busy && (restart || bit_end);
    assign int_eff  = apply ? int_shd : int_act;
    assign fsum     = {1'b0, facc} + {1'b0, frac_act};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_act  <= RST_INT;
            frac_act <= RST_FRAC;
            int_shd  <= RST_INT;
            frac_shd <= RST_FRAC;
            div_busy <= 1'b0;
            cnt      <= RST_INT - INT_W'(1);
            facc     <= '0;
            os_idx   <= '0;
            os_en    <= 1'b0;
            mid_en   <= 1'b0;
            bit_en   <= 1'b0;
        end else begin
            if (bus.divLoad) begin
                int_shd  <= clamp_int(bus.divInt);
                frac_shd <= bus.divFrac;
            end
            // A load coinciding with an apply leaves the new value pending.
            div_busy <= bus.divLoad || (div_busy && !apply);
            if (apply) begin
                int_act  <= int_shd;
                frac_act <= frac_shd;
            end

            // NOTE: enables default low every edge so each tick is exactly one cycle wide.
            os_en  <= 1'b0;
            mid_en <= 1'b0;
            bit_en <= 1'b0;

            if (restart) begin
                cnt    <= int_eff - INT_W'(1);
                facc   <= '0;
                os_idx <= '0;
            end else if (!terminal) begin
                cnt <= cnt - INT_W'(1);
            end else begin
                os_en  <= 1'b1;
                mid_en <= (os_idx == IDX_MID);
                bit_en <= (os_idx == IDX_LAST);
                os_idx <= os_idx + IDX_W'(1);
                if (apply) begin
                    cnt  <= int_eff - INT_W'(1);
                    facc <= '0;
                end else begin
                    cnt  <= int_act - INT_W'(1) + INT_W'(fsum[FRAC_W]);
                    facc <= fsum[FRAC_W-1:0];
                end
            end
        end
    end

    assign bus.divBusy = div_busy;
    assign bus.osEn    = os_en;
    assign bus.midEn   = mid_en;
    assign bus.bitEn   = bit_en;
endmodule

// File: tb/tb_dmx_frac_brg.sv
// Scoreboard bench for dmx_frac_brg: a period model pushes expected ticks,
// each observed osEn pops one and compares interval, midEn, bitEn and divBusy.
module tb_dmx_frac_brg;
    localparam int OS    = 16;
    localparam int FSCL  = 256;
    localparam int LIMIT = 1000;

    typedef struct {
        int dt;
        bit mid;
        bit bt;
        bit busy;
    } tick_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmx_frac_brg_if bus ();

    dmx_frac_brg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stray = 0;
    always @(negedge clk)
        if (!bus.osEn && (bus.midEn || bus.bitEn)) stray <= stray + 1;

    int checks = 0;
    int errors = 0;
    int last   = 0;

    tick_t sbq[$];
    int m_int, m_frac, m_facc, m_idx, m_next;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_restart(input int i, input int f);
        m_int  = i;
        m_frac = f;
        m_facc = 0;
        m_idx  = 0;
        m_next = i;
    endfunction

    // Each tick: its interval, then the fraction accumulation decides the next interval.
    function automatic void model_push(input int n, input bit busy);
        int sum;
        for (int k = 0; k < n; k++) begin
            sbq.push_back('{m_next, m_idx == OS/2-1, m_idx == OS-1, busy});
            sum    = m_facc + m_frac;
            m_facc = sum % FSCL;
            m_next = m_int + sum / FSCL;
            m_idx  = (m_idx + 1) % OS;
        end
    endfunction

    // Bit-end tick that switches divisor: the fraction residue is discarded.
    function automatic void model_push_apply(input int i, input int f);
        sbq.push_back('{m_next, m_idx == OS/2-1, m_idx == OS-1, 1'b0});
        m_idx  = (m_idx + 1) % OS;
        m_int  = i;
        m_frac = f;
        m_facc = 0;
        m_next = i;
    endfunction

    task automatic consume(input int n, input string tag);
        tick_t e;
        int    w;
        for (int k = 0; k < n; k++) begin
            if (sbq.size() == 0) begin
                check({tag, ".queue"}, 32'(sbq.size()), 32'd1);
                return;
            end
            e = sbq.pop_front();
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!bus.osEn && w < LIMIT);
            if (!bus.osEn) begin
                check({tag, ".timeout"}, 32'(bus.osEn), 32'd1);
                return;
            end
            check({tag, ".dt"},   32'(cyc - last), 32'(e.dt));
            check({tag, ".mid"},  32'(bus.midEn),  32'(e.mid));
            check({tag, ".bit"},  32'(bus.bitEn),  32'(e.bt));
            check({tag, ".busy"}, 32'(bus.divBusy), 32'(e.busy));
            last = cyc;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".os"},  32'(bus.osEn),  32'd0);
        check({tag, ".mid"}, 32'(bus.midEn), 32'd0);
        check({tag, ".bit"}, 32'(bus.bitEn), 32'd0);
    endtask

    initial begin
        int hits;
        bus.run     = 1'b0;
        bus.sync    = 1'b0;
        bus.divLoad = 1'b0;
        bus.divInt  = '0;
        bus.divFrac = '0;

        // Reset state.
        #3;
        check_idle("rst0");
        check("rst0.busy", 32'(bus.divBusy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");

        // Default 12/128: intervals 12,13 alternating; bits every 200, midEn 100 after bitEn.
        bus.run = 1'b1;
        last = cyc;
        model_restart(12, 128);
        model_push(32, 1'b0);
        consume(32, "dflt");

        // Load 4/0 mid-bit: pending until the bit end, then a 64-clock bit.
        model_push(4, 1'b0);
        consume(4, "pre4");
        bus.divInt  = 16'd4;
        bus.divFrac = 8'd0;
        bus.divLoad = 1'b1;
        @(negedge clk);
        bus.divLoad = 1'b0;
        check("ld4.busy", 32'(bus.divBusy), 32'd1);
        model_push(11, 1'b1);
        model_push_apply(4, 0);
        model_push(16, 1'b0);
        consume(28, "div4");

        // Idle load of 1/0 clamps to 2; busy for exactly one cycle.
        bus.run = 1'b0;
        @(negedge clk);
        check_idle("stop");
        bus.divInt  = 16'd1;
        bus.divFrac = 8'd0;
        bus.divLoad = 1'b1;
        @(negedge clk);
        bus.divLoad = 1'b0;
        check("ld1.busy", 32'(bus.divBusy), 32'd1);
        @(negedge clk);
        check("ld1.busy_clr", 32'(bus.divBusy), 32'd0);
        bus.run = 1'b1;
        last = cyc;
        model_restart(2, 0);
        model_push(32, 1'b0);
        consume(32, "clamp");

        // Back to 12/128, then sync exactly on a terminal-count cycle.
        bus.run     = 1'b0;
        bus.divInt  = 16'd12;
        bus.divFrac = 8'd128;
        bus.divLoad = 1'b1;
        @(negedge clk);
        bus.divLoad = 1'b0;
        @(negedge clk);
        bus.run = 1'b1;
        last = cyc;
        model_restart(12, 128);
        model_push(3, 1'b0);
        consume(3, "presync");
        repeat (m_next - 1) @(negedge clk);
        bus.sync = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        check_idle("sync");
        last = cyc;
        model_restart(12, 128);
        model_push(20, 1'b0);
        consume(20, "postsync");

        // run dropped mid-bit: no further enables at all.
        bus.run = 1'b0;
        hits = 0;
        repeat (250) begin
            @(negedge clk);
            if (bus.osEn || bus.bitEn || bus.midEn) hits++;
        end
        check("runoff.ticks", 32'(hits), 32'd0);

        // Async reset between edges while osEn and divBusy are high.
        bus.divInt  = 16'd4;
        bus.divFrac = 8'd0;
        bus.divLoad = 1'b1;
        @(negedge clk);
        bus.divLoad = 1'b0;
        @(negedge clk);
        bus.run = 1'b1;
        last = cyc;
        model_restart(4, 0);
        model_push(5, 1'b0);
        consume(5, "pre_rst");
        bus.divInt  = 16'd9;
        bus.divLoad = 1'b1;
        @(negedge clk);
        bus.divLoad = 1'b0;
        model_push(1, 1'b1);
        consume(1, "pend9");
        #2 rst = 1'b1;
        #1;
        check_idle("arst");
        check("arst.busy", 32'(bus.divBusy), 32'd0);
        @(negedge clk);
        check_idle("arst_hold");
        rst = 1'b0;
        last = cyc;
        model_restart(12, 128);
        model_push(17, 1'b0);
        consume(17, "post_rst");

        // Back-to-back loads 8/0 then 6/64: only 6/64 lands at the bit end.
        // The first 6/64 bit is 99 clocks (residue cleared), the next one 100.
        model_push(3, 1'b0);
        consume(3, "pre_b2b");
        bus.divInt  = 16'd8;
        bus.divFrac = 8'd0;
        bus.divLoad = 1'b1;
        @(negedge clk);
        bus.divInt  = 16'd6;
        bus.divFrac = 8'd64;
        @(negedge clk);
        bus.divLoad = 1'b0;
        check("b2b.busy", 32'(bus.divBusy), 32'd1);
        model_push(11, 1'b1);
        model_push_apply(6, 64);
        model_push(32, 1'b0);
        consume(44, "div6");

        check("sb.empty", 32'(sbq.size()), 32'd0);
        check("stray", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
